alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage directly upstream of the 32-bit ALU datapath, including the gated barrel shifter. It accepts one operation request per cycle over a valid/ready handshake and buffers it in a 2-entry skid buffer. It presents the shifter and the other units with registered operands, one-hot unit enables and a per-op saturation flag. Shift amounts of 32 or more clear the shifter enable, so the ALU returns 0 instead of wrapping modulo 32.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset; asynchronous assert, active-high.
- InValid  input  1  request valid.
- InReady  output  1  stage can accept a request.
- InOp  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6–7 reserved (treated as NOP).
- InA  input  32  operand A; shifter data.
- InB  input  32  operand B; shift amount for SLL.
- InFwdA  input  1  replace A with the forwarded result (FORWARD_EN only).
- ResValid  input  1  ALU result valid (FORWARD_EN only).
- ResIn  input  32  ALU result (FORWARD_EN only).
- OutValid  output  1  issued operation valid.
- OutReady  input  1  ALU consumes the operation.
- In1  output  32  operand to ALU/shifter.
- In2  output  32  operand to ALU/shifter; for SLL, bits [4:0] only.
- AddEn, SubSel, LogicEn, ShiftEn  output  1 each  unit enables; ShiftEn drives shifter Enable.
- LogicSel  output  2  0 AND, 1 OR, 2 XOR.
- OpErr  output  1  issued op was reserved.

## Operation
- A request is accepted on a cycle with InValid&&InReady.
- An issued op is consumed on a cycle with OutValid&&OutReady.
- Storage is an output register (entry 0) plus a skid register (entry 1). Occupancy states: EMPTY, ONE, FULL.
  - EMPTY + accept -> ONE.
  - ONE + accept, no consume -> FULL.
  - ONE + consume, no accept -> EMPTY.
  - ONE + accept + consume -> ONE; the new op loads entry 0.
  - FULL + consume -> ONE; entry 1 moves to entry 0.
  - InReady is 0 in FULL, so no accept can occur there.
- Decode happens at capture, and the decoded fields are stored with each entry.
- Enable outputs are exactly one-hot over {AddEn, LogicEn, ShiftEn} for valid ops, or all 0.
- SUB: AddEn=1, SubSel=1.
- SLL: ShiftEn=1 only when InB[31:5]==0; otherwise ShiftEn=0, so the shifter output is 0.
- In2 is passed through unmodified.
- Reserved op: all enables 0, OpErr=1, still issued (ALU result 0).
- Outputs hold stable while OutValid&&!OutReady.
- Ordering is strictly FIFO.

## Timing
- Reset values: InReady=1, OutValid=0, In1=0, In2=0, all enables 0, LogicSel=0, OpErr=0, occupancy EMPTY.
- Rst asserted mid-operation discards both entries immediately (asynchronous).
- Latency: accept at edge N -> OutValid=1 after edge N, with In1/In2/enables valid at the same time.
- Throughput: 1 op/cycle while OutReady=1.
- InReady is a register output and depends only on occupancy; there is no combinational path from OutReady to InReady.
- InReady falls the cycle after FULL is entered and rises the cycle after a consume from FULL.
- When a request and a consume occur together, both take effect on the same edge.

## Configuration
- FORWARD_EN defined:
  - A 32-bit forward register plus valid bit loads ResIn on any cycle with ResValid=1; a new ResIn overwrites the old value.
  - A request with InFwdA=1 uses the forward register in place of InA, sampled at accept.
  - If the forward register is not yet valid, InA is used and OpErr=1.
  - If ResValid coincides with the accept, ResIn itself is used (bypass).
  - Rst clears the forward valid bit.
- FORWARD_EN undefined: InFwdA, ResValid and ResIn are ignored, and no forward register exists.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_SLL);
  - LogicSel encodings;
  - a decoded-control struct/typedef {AddEn, SubSel, LogicEn, ShiftEn, LogicSel, OpErr};
  - SHAMT_BITS=5.
- Sub-module alu_op_decode is purely combinational: opcode + InB -> decoded-control. It is instantiated once, before capture.

## Test plan
- Reset then single op: SLL, A=0x0000_0001, B=3 -> OutValid the next cycle, In1=1, In2=3, ShiftEn=1, AddEn=LogicEn=0; shifter result 0x8.
- SLL with B=32 -> ShiftEn=0, OpErr=0, In2=32; ALU result 0. SLL with B=0xFFFF_FFE1 -> ShiftEn=0.
- Backpressure: OutReady=0, issue ADD(5,7), then SUB(9,4), then a third request.
  - Required: InReady=0 after the second accept and the third request stalls; outputs hold ADD.
  - After OutReady=1: ADD, SUB, then the third op issue on consecutive cycles, in order.
- Streaming: 8 back-to-back ops with OutReady=1 -> 8 issues on consecutive cycles, InReady stays 1.
- Reserved op 7 -> OpErr=1 and all enables 0. Rst asserted while FULL -> OutValid=0 and InReady=1 immediately, without a clock edge.
- FORWARD_EN: ResValid with ResIn=0xDEAD_BEEF, then AND with InFwdA=1, B=0xFFFF_0000 -> In1=0xDEAD_BEEF, LogicSel=0. Same test with ResValid coincident with the accept -> bypass value is used.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU issue stage and its decoder.
//   - opcode encodings OP_ADD..OP_SLL (6 and 7 are reserved)
//   - LogicSel encodings for the logic unit
//   - skid-buffer occupancy encodings
//   - alu_ctrl_t: the decoded per-op control bundle
//   - issue_entry_t: one buffered operation (operands + decoded control)
//   - SHAMT_BITS: number of meaningful shift-amount bits for SLL
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_BITS = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;

  localparam logic [1:0] LSEL_AND = 2'd0;
  localparam logic [1:0] LSEL_OR  = 2'd1;
  localparam logic [1:0] LSEL_XOR = 2'd2;

  // Occupancy of the two-entry skid buffer.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic       add_en;
    logic       sub_sel;
    logic       logic_en;
    logic       shift_en;
    logic [1:0] logic_sel;
    logic       op_err;
  } alu_ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_ctrl_t         ctrl;
  } issue_entry_t;

  // Control bundle with every unit disabled.
  function automatic alu_ctrl_t ctrl_idle();
    alu_ctrl_t c;
    c.add_en    = 1'b0;
    c.sub_sel   = 1'b0;
    c.logic_en  = 1'b0;
    c.shift_en  = 1'b0;
    c.logic_sel = LSEL_AND;
    c.op_err    = 1'b0;
    return c;
  endfunction

  // A shift amount is usable only if every bit above the shamt field is 0;
  // larger amounts must produce 0 rather than wrap modulo 32.
  function automatic logic shamt_in_range(input logic [DATA_W-SHAMT_BITS-1:0] b_hi);
    return (b_hi == '0);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational opcode decoder.
//   op_i   [2:0]  opcode (OP_* from alu_pkg; 6-7 reserved)
//   b_i    [31:0] operand B; only its upper bits matter (SLL range check)
//   ctrl_o        decoded control: exactly one unit enable for a valid op,
//                 none for a reserved op (which raises op_err instead)
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] b_i,
  output alu_ctrl_t         ctrl_o
);

  // Low shamt bits are consumed by the shifter itself, not by decode.
  logic unused_shamt;
  assign unused_shamt = ^b_i[SHAMT_BITS-1:0];

  always_comb begin
    ctrl_o = ctrl_idle();
    case (op_i)
      OP_ADD: ctrl_o.add_en = 1'b1;
      OP_SUB: begin
        ctrl_o.add_en  = 1'b1;
        ctrl_o.sub_sel = 1'b1;
      end
      OP_AND: begin
        ctrl_o.logic_en  = 1'b1;
        ctrl_o.logic_sel = LSEL_AND;
      end
      OP_OR: begin
        ctrl_o.logic_en  = 1'b1;
        ctrl_o.logic_sel = LSEL_OR;
      end
      OP_XOR: begin
        ctrl_o.logic_en  = 1'b1;
        ctrl_o.logic_sel = LSEL_XOR;
      end
      // Out-of-range amounts gate the shifter off, so the ALU returns 0.
      OP_SLL: ctrl_o.shift_en = shamt_in_range(b_i[DATA_W-1:SHAMT_BITS]);
      default: ctrl_o.op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the 32-bit ALU.
// Requests arrive over valid/ready, are decoded at capture and held in a
// two-entry skid buffer (entry 0 drives the outputs, entry 1 is the skid).
//
// Optional feature macro: FORWARD_EN (result-forwarding register for A).
//
// Ports:
//   Clk, Rst               clock (rising edge), async active-high reset
//   InValid/InReady        request handshake; InReady is registered
//   InOp, InA, InB         opcode and operands of the request
//   InFwdA                 use the forwarded result instead of InA
//   ResValid, ResIn        ALU result feeding the forward register
//   OutValid/OutReady      issue handshake towards the ALU
//   In1, In2               registered operands (In2 unmodified)
//   AddEn, SubSel, LogicEn, ShiftEn, LogicSel, OpErr  decoded control
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W  // only 32 is supported
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       InOp,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             InFwdA,
  input  logic             ResValid,
  input  logic [WIDTH-1:0] ResIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] In1,
  output logic [WIDTH-1:0] In2,
  output logic             AddEn,
  output logic             SubSel,
  output logic             LogicEn,
  output logic             ShiftEn,
  output logic [1:0]       LogicSel,
  output logic             OpErr
);

  logic [1:0]   occ_q, occ_d;
  logic         in_ready_q, in_ready_d;
  issue_entry_t entry0_q, entry0_d;
  issue_entry_t entry1_q, entry1_d;

  logic         accept;
  logic         consume;
  logic [WIDTH-1:0] opa;
  logic         fwd_err;
  alu_ctrl_t    dec_ctrl;
  issue_entry_t cap_entry;

  // ---------------------------------------------------------------------
  // Operand A selection
  // ---------------------------------------------------------------------
`ifdef FORWARD_EN
  logic [WIDTH-1:0] fwd_q;
  logic             fwd_valid_q;

  // Always holds the most recent result seen; newer results overwrite.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fwd_q       <= '0;
      fwd_valid_q <= 1'b0;
    end else if (ResValid) begin
      fwd_q       <= ResIn;
      fwd_valid_q <= 1'b1;
    end
  end

  // A result arriving in the accept cycle is newer than the register, so
  // it is bypassed straight in. Without any result yet, fall back to InA
  // and flag the op.
  always_comb begin
    opa     = InA;
    fwd_err = 1'b0;
    if (InFwdA) begin
      if (ResValid) begin
        opa = ResIn;
      end else if (fwd_valid_q) begin
        opa = fwd_q;
      end else begin
        fwd_err = 1'b1;
      end
    end
  end
`else
  assign opa     = InA;
  assign fwd_err = 1'b0;

  logic unused_fwd;
  assign unused_fwd = ^{InFwdA, ResValid, ResIn};
`endif

  // ---------------------------------------------------------------------
  // Decode at capture time
  // ---------------------------------------------------------------------
  alu_op_decode u_decode (
    .op_i   (InOp),
    .b_i    (InB),
    .ctrl_o (dec_ctrl)
  );

  always_comb begin
    cap_entry             = '0;
    cap_entry.a           = opa;
    cap_entry.b           = InB;
    cap_entry.ctrl        = dec_ctrl;
    cap_entry.ctrl.op_err = dec_ctrl.op_err | fwd_err;
  end

  // ---------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------
  assign accept  = InValid && in_ready_q;
  assign consume = (occ_q != OCC_EMPTY) && OutReady;

  always_comb begin
    occ_d    = occ_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          entry0_d = cap_entry;
          occ_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && consume) begin
          // Entry 0 leaves and is replaced on the same edge.
          entry0_d = cap_entry;
        end else if (accept) begin
          // Entry 0 must hold stable under backpressure; park in skid.
          entry1_d = cap_entry;
          occ_d    = OCC_FULL;
        end else if (consume) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // InReady is low here, so only a consume can happen.
        if (consume) begin
          entry0_d = entry1_q;
          occ_d    = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // Registered ready derived from next occupancy only, so OutReady never
    // reaches InReady combinationally.
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      entry0_q   <= '0;
      entry1_q   <= '0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: everything comes from entry 0 registers
  // ---------------------------------------------------------------------
  assign InReady  = in_ready_q;
  assign OutValid = (occ_q != OCC_EMPTY);
  assign In1      = entry0_q.a;
  assign In2      = entry0_q.b;
  assign AddEn    = entry0_q.ctrl.add_en;
  assign SubSel   = entry0_q.ctrl.sub_sel;
  assign LogicEn  = entry0_q.ctrl.logic_en;
  assign ShiftEn  = entry0_q.ctrl.shift_en;
  assign LogicSel = entry0_q.ctrl.logic_sel;
  assign OpErr    = entry0_q.ctrl.op_err;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_alu_issue_stage;

  logic        Clk;
  logic        Rst;
  logic        InValid;
  logic        InReady;
  logic [2:0]  InOp;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        InFwdA;
  logic        ResValid;
  logic [31:0] ResIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        AddEn;
  logic        SubSel;
  logic        LogicEn;
  logic        ShiftEn;
  logic [1:0]  LogicSel;
  logic        OpErr;

  int tests;
  int fails;

  alu_issue_stage #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InOp     (InOp),
    .InA      (InA),
    .InB      (InB),
    .InFwdA   (InFwdA),
    .ResValid (ResValid),
    .ResIn    (ResIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .In1      (In1),
    .In2      (In2),
    .AddEn    (AddEn),
    .SubSel   (SubSel),
    .LogicEn  (LogicEn),
    .ShiftEn  (ShiftEn),
    .LogicSel (LogicSel),
    .OpErr    (OpErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    InValid = v;
    InOp    = op;
    InA     = a;
    InB     = b;
  endtask

  // Reference gated barrel shifter downstream of the stage.
  function automatic logic [31:0] shifter(input logic en, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    return en ? (a << sh) : 32'h0;
  endfunction

  logic [2:0]  s_op [8];
  logic [31:0] s_a  [8];
  logic [31:0] s_b  [8];

  initial begin
    tests = 0;
    fails = 0;
    Rst = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    InFwdA = 1'b0; ResValid = 1'b0; ResIn = 32'h0; OutReady = 1'b0;

    // ---------------- reset state ----------------
    #7;
    chk("rst_in_ready", {31'b0, InReady}, 32'd1);
    chk("rst_out_valid", {31'b0, OutValid}, 32'd0);
    chk("rst_in1", In1, 32'h0);
    chk("rst_in2", In2, 32'h0);
    chk("rst_enables", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'h0);
    chk("rst_lsel_err", {29'b0, LogicSel, OpErr}, 32'h0);
    tick();
    Rst = 1'b0;
    tick();

    // ---------------- single SLL 1<<3 ----------------
    drive(1'b1, 3'd5, 32'h1, 32'd3);
    OutReady = 1'b1;
    tick();
    $display("[TB] txn SLL A=1 B=3 -> In1=%h In2=%h ShiftEn=%b", In1, In2, ShiftEn);
    chk("sll3_valid", {31'b0, OutValid}, 32'd1);
    chk("sll3_in1", In1, 32'h1);
    chk("sll3_in2", In2, 32'd3);
    chk("sll3_en", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'h1);
    chk("sll3_result", shifter(ShiftEn, In1, In2), 32'h8);

    // ---------------- SLL B=32 (consumed+accepted same edge) ----------------
    drive(1'b1, 3'd5, 32'h1, 32'd32);
    tick();
    $display("[TB] txn SLL A=1 B=32 -> In2=%h ShiftEn=%b OpErr=%b", In2, ShiftEn, OpErr);
    chk("sll32_valid", {31'b0, OutValid}, 32'd1);
    chk("sll32_shift_en", {31'b0, ShiftEn}, 32'd0);
    chk("sll32_op_err", {31'b0, OpErr}, 32'd0);
    chk("sll32_in2", In2, 32'd32);
    chk("sll32_result", shifter(ShiftEn, In1, In2), 32'h0);

    drive(1'b1, 3'd5, 32'h1, 32'hFFFF_FFE1);
    tick();
    $display("[TB] txn SLL A=1 B=FFFFFFE1 -> In2=%h ShiftEn=%b", In2, ShiftEn);
    chk("sllneg_in2", In2, 32'hFFFF_FFE1);
    chk("sllneg_shift_en", {31'b0, ShiftEn}, 32'd0);
    chk("sllneg_result", shifter(ShiftEn, In1, In2), 32'h0);

    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    chk("drain_out_valid", {31'b0, OutValid}, 32'd0);

    // ---------------- backpressure ----------------
    OutReady = 1'b0;
    drive(1'b1, 3'd0, 32'd5, 32'd7);
    tick();
    $display("[TB] txn ADD 5,7 accepted, In1=%h In2=%h InReady=%b", In1, In2, InReady);
    chk("bp_add_in1", In1, 32'd5);
    chk("bp_add_in2", In2, 32'd7);
    chk("bp_add_en", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'h8);
    chk("bp_ready_one", {31'b0, InReady}, 32'd1);

    drive(1'b1, 3'd1, 32'd9, 32'd4);
    tick();
    $display("[TB] txn SUB 9,4 accepted into skid, InReady=%b In1=%h", InReady, In1);
    chk("bp_ready_full", {31'b0, InReady}, 32'd0);
    chk("bp_hold_in1", In1, 32'd5);
    chk("bp_hold_sub", {31'b0, SubSel}, 32'd0);

    drive(1'b1, 3'd4, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    tick();
    $display("[TB] txn XOR stalled, InReady=%b In1=%h In2=%h", InReady, In1, In2);
    chk("bp_stall_ready", {31'b0, InReady}, 32'd0);
    chk("bp_stall_in1", In1, 32'd5);
    chk("bp_stall_in2", In2, 32'd7);
    chk("bp_stall_valid", {31'b0, OutValid}, 32'd1);

    OutReady = 1'b1;
    tick();
    $display("[TB] txn consume ADD -> In1=%h In2=%h SubSel=%b", In1, In2, SubSel);
    chk("bp_sub_in1", In1, 32'd9);
    chk("bp_sub_in2", In2, 32'd4);
    chk("bp_sub_en", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'hC);
    chk("bp_sub_ready", {31'b0, InReady}, 32'd1);

    tick();
    $display("[TB] txn consume SUB, accept XOR -> In1=%h LogicSel=%0d", In1, LogicSel);
    chk("bp_xor_in1", In1, 32'h0000_F0F0);
    chk("bp_xor_in2", In2, 32'h0000_0FF0);
    chk("bp_xor_en", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'h2);
    chk("bp_xor_sel", {30'b0, LogicSel}, 32'd2);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    chk("bp_empty", {31'b0, OutValid}, 32'd0);

    // ---------------- streaming 8 back-to-back ----------------
    s_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd3};
    for (int i = 0; i < 8; i++) begin
      s_a[i] = 32'h100 + i;
      s_b[i] = 32'h20 + i;
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s_op[i], s_a[i], s_b[i]);
      tick();
      $display("[TB] txn stream %0d op=%0d In1=%h In2=%h InReady=%b", i, s_op[i], In1, In2, InReady);
      chk("stream_valid", {31'b0, OutValid}, 32'd1);
      chk("stream_in1", In1, s_a[i]);
      chk("stream_in2", In2, s_b[i]);
      chk("stream_ready", {31'b0, InReady}, 32'd1);
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    chk("stream_drain", {31'b0, OutValid}, 32'd0);

    // ---------------- reserved op and async reset while FULL ----------------
    OutReady = 1'b0;
    drive(1'b1, 3'd7, 32'd3, 32'd4);
    tick();
    $display("[TB] txn reserved op 7 -> OpErr=%b enables=%b%b%b%b", OpErr, AddEn, SubSel, LogicEn, ShiftEn);
    chk("rsv_valid", {31'b0, OutValid}, 32'd1);
    chk("rsv_op_err", {31'b0, OpErr}, 32'd1);
    chk("rsv_enables", {28'b0, AddEn, SubSel, LogicEn, ShiftEn}, 32'h0);
    chk("rsv_in1", In1, 32'd3);

    drive(1'b1, 3'd0, 32'd1, 32'd2);
    tick();
    chk("full_ready", {31'b0, InReady}, 32'd0);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    Rst = 1'b1;
    #1;
    $display("[TB] txn async reset while FULL -> OutValid=%b InReady=%b", OutValid, InReady);
    chk("arst_out_valid", {31'b0, OutValid}, 32'd0);
    chk("arst_in_ready", {31'b0, InReady}, 32'd1);
    chk("arst_op_err", {31'b0, OpErr}, 32'd0);
    chk("arst_in1", In1, 32'h0);
    tick();
    Rst = 1'b0;
    OutReady = 1'b1;
    tick();

`ifdef FORWARD_EN
    // ---------------- forwarding ----------------
    InFwdA = 1'b1;
    drive(1'b1, 3'd0, 32'h55, 32'h1);
    tick();
    $display("[TB] txn fwd not valid -> In1=%h OpErr=%b", In1, OpErr);
    chk("fwd_none_in1", In1, 32'h55);
    chk("fwd_none_err", {31'b0, OpErr}, 32'd1);

    InValid = 1'b0; InFwdA = 1'b0;
    ResValid = 1'b1; ResIn = 32'hDEAD_BEEF;
    tick();
    ResValid = 1'b0; ResIn = 32'h0;
    InFwdA = 1'b1;
    drive(1'b1, 3'd2, 32'h1234_5678, 32'hFFFF_0000);
    tick();
    $display("[TB] txn fwd AND -> In1=%h LogicSel=%0d OpErr=%b", In1, LogicSel, OpErr);
    chk("fwd_in1", In1, 32'hDEAD_BEEF);
    chk("fwd_in2", In2, 32'hFFFF_0000);
    chk("fwd_sel", {30'b0, LogicSel}, 32'd0);
    chk("fwd_logic_en", {31'b0, LogicEn}, 32'd1);
    chk("fwd_err", {31'b0, OpErr}, 32'd0);

    ResValid = 1'b1; ResIn = 32'hCAFE_F00D;
    drive(1'b1, 3'd2, 32'h1234_5678, 32'hFFFF_0000);
    tick();
    $display("[TB] txn fwd bypass AND -> In1=%h", In1);
    chk("byp_in1", In1, 32'hCAFE_F00D);
    chk("byp_err", {31'b0, OpErr}, 32'd0);
    ResValid = 1'b0; InFwdA = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
`else
    // ---------------- forwarding inputs ignored ----------------
    InFwdA = 1'b1; ResValid = 1'b1; ResIn = 32'hDEAD_BEEF;
    drive(1'b1, 3'd2, 32'h1234_5678, 32'hFFFF_0000);
    tick();
    $display("[TB] txn AND with fwd inputs ignored -> In1=%h OpErr=%b", In1, OpErr);
    chk("nofwd_in1", In1, 32'h1234_5678);
    chk("nofwd_err", {31'b0, OpErr}, 32'd0);
    chk("nofwd_sel", {30'b0, LogicSel}, 32'd0);
    InFwdA = 1'b0; ResValid = 1'b0; ResIn = 32'h0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
`endif

    chk("final_empty", {31'b0, OutValid}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
